// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion, default widths, skid-buffer states.
package fifo_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned GRAY_MAX_W         = 32;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Zero-extended inputs convert correctly: leading zero Gray bits give zero binary bits.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop clock-domain-crossing synchronizer for Gray-coded pointers.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // No logic between the stages so each bit has a full cycle to resolve.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/fifo_wr_source.sv
// Write-domain FIFO producer: 2-entry skid buffer from a valid/ready stream,
// read-pointer synchronizer, and registered fill level / almost_full.
module fifo_wr_source
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned AF_THRESH  = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] w_data,
  input  logic                  full,
  input  logic [ADDR_WIDTH:0]   w_ptr,
  input  logic [ADDR_WIDTH:0]   r_ptr,
  output logic [ADDR_WIDTH:0]   w_q2_rptr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  s_ready_q, s_ready_d;
  logic                  w_en_q, w_en_d;
  logic [PTR_W-1:0]      level_q, level_d;
  logic                  af_q, af_d;
  logic [PTR_W-1:0]      rptr_sync;
  logic [PTR_W-1:0]      wbin, rbin;
  logic                  accept, pop;

  assign accept = s_valid && s_ready_q;
  assign pop    = w_en_q && !full;

  sync_2ff #(
    .WIDTH(PTR_W)
  ) u_rptr_sync (
    .clk_i  (w_clk),
    .rst_n_i(w_rst_n),
    .d_i    (r_ptr),
    .q_o    (rptr_sync)
  );

  // Skid buffer next state; head is always the oldest word.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d = SKID_ONE;
          head_d  = s_data;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          head_d = s_data;
        end else if (accept) begin
          state_d = SKID_TWO;
          tail_d  = s_data;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          state_d = SKID_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    s_ready_d = (state_d != SKID_TWO);
    w_en_d    = (state_d != SKID_EMPTY);
  end

  // Occupancy from the lagging read pointer, so it can only over-report.
  always_comb begin
    wbin    = PTR_W'(gray2bin(GRAY_MAX_W'(w_ptr)));
    rbin    = PTR_W'(gray2bin(GRAY_MAX_W'(rptr_sync)));
    level_d = PTR_W'(wbin - rbin);
    af_d    = (32'(level_d) >= AF_THRESH);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= SKID_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      s_ready_q <= 1'b0;
      w_en_q    <= 1'b0;
      level_q   <= '0;
      af_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= s_ready_d;
      w_en_q    <= w_en_d;
      level_q   <= level_d;
      af_q      <= af_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign w_en        = w_en_q;
  assign w_data      = head_q;
  assign w_q2_rptr   = rptr_sync;
  assign level       = level_q;
  assign almost_full = af_q;

endmodule
